// File: rtl/dds_pkg.sv
// dds_pkg: shared DDS FIFO selects, idle address and sequencer states
package dds_pkg;
  typedef enum logic [1:0] {THETAS = 2'd0, DELTAS = 2'd1, AMPLS = 2'd2} dds_sel_e;
  typedef enum logic [1:0] {IDLE, RST, LOAD, RUN} dds_seq_state_e;
  localparam logic [8:0] IDLE_ADDR = 9'h1FF;
endpackage

// File: rtl/dds_cfg_bank.sv
// dds_cfg_bank: per-channel shadow theta/delta/amplitude words
module dds_cfg_bank #(
  parameter int SIG_WIDTH = 16,
  parameter int NUM_CH = 8,
  parameter int CH_W = $clog2(NUM_CH)
) (
  input  logic                 clk,
  input  logic                 a_rst_n,
  input  logic                 we,
  input  logic [CH_W-1:0]      wr_ch,
  input  logic [1:0]           wr_sel,
  input  logic [SIG_WIDTH-1:0] wr_data,
  input  logic [CH_W-1:0]      rd_ch,
  input  logic [1:0]           rd_sel,
  output logic [SIG_WIDTH-1:0] rd_data
);
  logic [SIG_WIDTH-1:0] mem [NUM_CH][3];
  always_ff @(posedge clk or negedge a_rst_n)
    if (!a_rst_n) begin
      for (int c = 0; c < NUM_CH; c++)
        for (int s = 0; s < 3; s++) mem[c][s] <= '0;
    end else if (we) mem[wr_ch][wr_sel] <= wr_data;
  assign rd_data = (rd_sel == 2'd3 || 32'(rd_ch) >= NUM_CH) ? '0 : mem[rd_ch][rd_sel];
endmodule

// File: rtl/dds_seq_ctrl.sv
// dds_seq_ctrl: configures, loads and starts/stops the time-multiplexed DDS core
module dds_seq_ctrl import dds_pkg::*; #(
  parameter int SIG_WIDTH = 16,
  parameter int NUM_CH = 8,
  parameter int CH_W = $clog2(NUM_CH)
) (
  input  logic                 clk,
  input  logic                 a_rst_n,
  input  logic                 i_cfg_valid,
  output logic                 o_cfg_ready,
  input  logic [CH_W-1:0]      i_cfg_ch,
  input  logic [1:0]           i_cfg_sel,
  input  logic [SIG_WIDTH-1:0] i_cfg_data,
  output logic                 o_cfg_err,
  input  logic                 i_cmd_start,
  input  logic                 i_cmd_stop,
  output logic                 o_dds_rst,
  output logic                 o_dds_start,
  output logic [8:0]           o_dds_addrs,
  output logic [SIG_WIDTH-1:0] o_dds_fifo_data,
  output logic                 o_running,
  output logic                 o_busy,
  output logic                 o_load_done,
  output logic [CH_W-1:0]      o_ch_idx
);
  dds_seq_state_e state, nxt;
  logic [1:0] ld_sel, n_sel;
  logic [CH_W-1:0] ld_ch, n_ch;
  logic [SIG_WIDTH-1:0] rd_data;
  logic acc, bad, in_load, ch_wrap, last, idx_wrap;
  assign o_cfg_ready = state == IDLE || state == RUN;
  assign o_dds_rst = state == RST;
  assign o_dds_start = state == RUN;
  assign o_running = state == RUN;
  assign o_busy = state == RST || state == LOAD;
  assign acc = i_cfg_valid && o_cfg_ready;
  assign bad = i_cfg_sel == 2'd3 || 32'(i_cfg_ch) >= NUM_CH;
  assign in_load = state == LOAD;
  assign ch_wrap = 32'(ld_ch) == NUM_CH - 1;
  assign last = ld_sel == AMPLS && ch_wrap;
  assign idx_wrap = 32'(o_ch_idx) == NUM_CH - 1;
  // ld_ch/ld_sel name the word currently on the bus; n_* is the one registered next
  assign n_ch = in_load && !ch_wrap ? ld_ch + 1'b1 : '0;
  assign n_sel = !in_load ? 2'd0 : ch_wrap ? ld_sel + 2'd1 : ld_sel;
  always_ff @(posedge clk or negedge a_rst_n)
    if (!a_rst_n) state <= IDLE;
    else state <= nxt;
  always_comb begin
    nxt = state;
    case (state)
      IDLE:    nxt = i_cmd_start && !i_cmd_stop ? RST : IDLE;
      RST:     nxt = i_cmd_stop ? IDLE : LOAD;
      LOAD:    nxt = i_cmd_stop ? IDLE : last ? RUN : LOAD;
      default: nxt = i_cmd_stop ? IDLE : i_cmd_start ? RST : RUN;
    endcase
  end
  always_ff @(posedge clk or negedge a_rst_n)
    if (!a_rst_n) begin
      ld_ch <= '0;
      ld_sel <= '0;
      o_dds_addrs <= IDLE_ADDR;
      o_dds_fifo_data <= '0;
      o_load_done <= 1'b0;
      o_ch_idx <= '0;
      o_cfg_err <= 1'b0;
    end else begin
      ld_ch <= n_ch;
      ld_sel <= n_sel;
      o_dds_addrs <= nxt == LOAD ? {7'd0, n_sel} : IDLE_ADDR;
      o_dds_fifo_data <= nxt == LOAD ? rd_data : '0;
      o_load_done <= state == LOAD && nxt == RUN;
      o_ch_idx <= state == RUN && nxt == RUN ? (idx_wrap ? '0 : o_ch_idx + 1'b1) : '0;
      o_cfg_err <= acc && bad;
    end
  dds_cfg_bank #(.SIG_WIDTH(SIG_WIDTH), .NUM_CH(NUM_CH), .CH_W(CH_W)) u_bank (
    .clk(clk),
    .a_rst_n(a_rst_n),
    .we(acc && !bad),
    .wr_ch(i_cfg_ch),
    .wr_sel(i_cfg_sel),
    .wr_data(i_cfg_data),
    .rd_ch(n_ch),
    .rd_sel(n_sel),
    .rd_data(rd_data)
  );
endmodule

// File: tb/tb_dds_seq_ctrl.sv
// tb_dds_seq_ctrl: timeline model plus directed checks for dds_seq_ctrl
module tb_dds_seq_ctrl;
  localparam int N = 4;
  localparam int RUN_T = 2 + 3 * N;
  logic clk = 0;
  logic a_rst_n;
  logic cfg_valid, cfg_ready, cfg_err, cmd_start, cmd_stop;
  logic [2:0] cfg_ch;
  logic [1:0] cfg_sel;
  logic [15:0] cfg_data, fifo_data;
  logic dds_rst, dds_start, running, busy, load_done;
  logic [8:0] addrs;
  logic [2:0] ch_idx;
  int n_chk = 0, n_err = 0;
  int m_t;
  bit m_act, m_err, m_rdy, m_ld, m_run;
  int k;
  logic [15:0] mb [N][3];
  logic [15:0] exp_w [3*N];

  always #5 clk = ~clk;

  dds_seq_ctrl #(.SIG_WIDTH(16), .NUM_CH(N), .CH_W(3)) dut (
    .clk(clk), .a_rst_n(a_rst_n),
    .i_cfg_valid(cfg_valid), .o_cfg_ready(cfg_ready), .i_cfg_ch(cfg_ch),
    .i_cfg_sel(cfg_sel), .i_cfg_data(cfg_data), .o_cfg_err(cfg_err),
    .i_cmd_start(cmd_start), .i_cmd_stop(cmd_stop),
    .o_dds_rst(dds_rst), .o_dds_start(dds_start), .o_dds_addrs(addrs),
    .o_dds_fifo_data(fifo_data), .o_running(running), .o_busy(busy),
    .o_load_done(load_done), .o_ch_idx(ch_idx)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // m_t counts cycles since the accepted start: 1 = reset pulse, 2..RUN_T-1 = load words, RUN_T.. = running
  always @(posedge clk or negedge a_rst_n) begin
    if (!a_rst_n) begin
      m_act = 0; m_t = 0; m_err = 0;
      for (int c = 0; c < N; c++) for (int s = 0; s < 3; s++) mb[c][s] = '0;
    end else begin
      m_rdy = !m_act || m_t >= RUN_T;
      m_err = cfg_valid && m_rdy && (cfg_sel == 2'd3 || cfg_ch >= 3'(N));
      if (cfg_valid && m_rdy && !m_err) mb[cfg_ch][cfg_sel] = cfg_data;
      if (!m_act) begin
        if (cmd_start && !cmd_stop) begin m_act = 1; m_t = 1; end
      end else if (cmd_stop) m_act = 0;
      else if (m_t >= RUN_T && cmd_start) m_t = 1;
      else m_t++;
    end
  end

  always @(negedge clk) begin
    m_ld = m_act && m_t >= 2 && m_t < RUN_T;
    m_run = m_act && m_t >= RUN_T;
    k = m_t - 2;
    chk("m_rst", dds_rst, m_act && m_t == 1);
    chk("m_start", dds_start, m_run);
    chk("m_running", running, m_run);
    chk("m_busy", busy, m_act && m_t < RUN_T);
    chk("m_ready", cfg_ready, !(m_act && m_t < RUN_T));
    chk("m_done", load_done, m_act && m_t == RUN_T);
    chk("m_err", cfg_err, m_err);
    chk("m_addrs", addrs, m_ld ? k / N : 9'h1FF);
    chk("m_data", fifo_data, m_ld ? mb[k % N][k / N] : 16'h0);
    chk("m_idx", ch_idx, m_run ? (m_t - RUN_T) % N : 0);
  end

  task automatic wr(input int ch, input int sel, input logic [15:0] d);
    cfg_valid = 1; cfg_ch = 3'(ch); cfg_sel = 2'(sel); cfg_data = d;
    @(negedge clk);
    cfg_valid = 0;
  endtask

  task automatic start_pulse();
    cmd_start = 1;
    @(negedge clk);
    cmd_start = 0;
  endtask

  task automatic load_chk(input string tag);
    start_pulse();
    chk({tag, "_rst"}, dds_rst, 1);
    for (int i = 0; i < 3 * N; i++) begin
      @(negedge clk);
      chk({tag, "_addr"}, addrs, i / N);
      chk({tag, "_word"}, fifo_data, exp_w[i]);
    end
    @(negedge clk);
    chk({tag, "_start"}, dds_start, 1);
    chk({tag, "_done"}, load_done, 1);
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_addrs"}, addrs, 9'h1FF);
    chk({tag, "_ready"}, cfg_ready, 1);
    chk({tag, "_start"}, dds_start, 0);
    chk({tag, "_rst"}, dds_rst, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_run"}, running, 0);
    chk({tag, "_data"}, fifo_data, 0);
    chk({tag, "_done"}, load_done, 0);
    chk({tag, "_idx"}, ch_idx, 0);
    chk({tag, "_err"}, cfg_err, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    cfg_valid = 0; cfg_ch = 0; cfg_sel = 0; cfg_data = 0; cmd_start = 0; cmd_stop = 0;
    a_rst_n = 1;
    #1 a_rst_n = 0;
    #2 chk_reset("por");
    @(negedge clk);
    @(negedge clk);
    a_rst_n = 1;
    @(negedge clk);
    for (int c = 0; c < N; c++) begin
      wr(c, 0, 16'(16'h1000 * c));
      wr(c, 1, 16'h0100);
      wr(c, 2, 16'(16'h0040 + c));
    end
    exp_w = '{16'h0000, 16'h1000, 16'h2000, 16'h3000, 16'h0100, 16'h0100, 16'h0100, 16'h0100,
              16'h0040, 16'h0041, 16'h0042, 16'h0043};
    load_chk("load1");
    for (int i = 1; i <= N; i++) begin
      @(negedge clk);
      chk("run_idx", ch_idx, i % N);
    end
    chk("run_done_once", load_done, 0);
    chk("run_ready", cfg_ready, 1);
    wr(2, 2, 16'h7FFF);
    chk("run_bus_addr", addrs, 9'h1FF);
    chk("run_bus_data", fifo_data, 0);
    exp_w[10] = 16'h7FFF;
    load_chk("reload");
    cmd_stop = 1;
    @(negedge clk);
    cmd_stop = 0;
    chk("stop_idle", running, 0);
    wr(1, 3, 16'hDEAD);
    chk("err_sel3", cfg_err, 1);
    @(negedge clk);
    chk("err_clear", cfg_err, 0);
    wr(5, 0, 16'hBEEF);
    chk("err_ch5", cfg_err, 1);
    @(negedge clk);
    wr(4, 1, 16'hBEEF);
    chk("err_ch4", cfg_err, 1);
    @(negedge clk);
    load_chk("after_err");
    cmd_stop = 1;
    @(negedge clk);
    cmd_stop = 0;
    start_pulse();
    repeat (6) @(negedge clk);
    chk("abort_k5_addr", addrs, 1);
    cmd_stop = 1;
    @(negedge clk);
    cmd_stop = 0;
    chk("abort_busy", busy, 0);
    chk("abort_addrs", addrs, 9'h1FF);
    chk("abort_start", dds_start, 0);
    repeat (3) @(negedge clk);
    chk("abort_start_hold", dds_start, 0);
    start_pulse();
    repeat (4) @(negedge clk);
    start_pulse();
    repeat (7) @(negedge clk);
    chk("ign_k11_start", dds_start, 0);
    chk("ign_k11_addr", addrs, 2);
    @(negedge clk);
    chk("ign_run_start", dds_start, 1);
    chk("ign_run_done", load_done, 1);
    repeat (2) @(negedge clk);
    cmd_start = 1; cmd_stop = 1;
    @(negedge clk);
    cmd_start = 0; cmd_stop = 0;
    chk("both_start", dds_start, 0);
    chk("both_rst", dds_rst, 0);
    chk("both_run", running, 0);
    @(negedge clk);
    chk("both_rst2", dds_rst, 0);
    start_pulse();
    repeat (RUN_T - 1 + 2) @(negedge clk);
    chk("pre_arst_run", running, 1);
    #2 a_rst_n = 0;
    #1 chk_reset("arst");
    @(negedge clk);
    a_rst_n = 1;
    @(negedge clk);
    for (int i = 0; i < 3 * N; i++) exp_w[i] = 16'h0;
    load_chk("zero_bank");
    repeat (2) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
